// File: rtl/shift_tx_driver.sv
// Parallel-to-serial driver for a SIPO shift stage: MSB-first sdata with generated sclk and cpy strobe.
// Optional SHIFT_TX_DRIVER_DONE_EN adds a one-cycle done pulse after each completed frame.
module shift_tx_driver #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sclk,
  output logic             sdata,
  output logic             cpy
`ifdef SHIFT_TX_DRIVER_DONE_EN
  ,
  output logic             done
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, COPY} state_t;

  state_t           state_reg;
  // Holds only the bits not yet placed on sdata; the MSB goes straight out on accept.
  logic [WIDTH-2:0] shreg_reg;
  logic [BIT_W-1:0] bitcnt_reg;
  logic [DIV_W-1:0] div_reg;
  logic             div_end;

  assign div_end   = (div_reg == DIV_LAST);
  assign din_ready = (state_reg == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      shreg_reg  <= '0;
      bitcnt_reg <= '0;
      div_reg    <= '0;
      sclk       <= 1'b0;
      sdata      <= 1'b0;
      cpy        <= 1'b0;
`ifdef SHIFT_TX_DRIVER_DONE_EN
      done       <= 1'b0;
`endif
    end else begin
`ifdef SHIFT_TX_DRIVER_DONE_EN
      done <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          sclk <= 1'b0;
          cpy  <= 1'b0;
          if (din_valid) begin
            shreg_reg  <= din[WIDTH-2:0];
            sdata      <= din[WIDTH-1];
            bitcnt_reg <= '0;
            div_reg    <= '0;
            state_reg  <= LO;
          end
        end
        LO: begin
          if (div_end) begin
            sclk      <= 1'b1;
            div_reg   <= '0;
            state_reg <= HI;
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        HI: begin
          if (div_end) begin
            sclk    <= 1'b0;
            div_reg <= '0;
            // sdata only moves on the falling sclk edge, giving a full half-period of setup and hold.
            if (bitcnt_reg != BIT_LAST) begin
              sdata      <= shreg_reg[WIDTH-2];
              shreg_reg  <= shreg_reg << 1;
              bitcnt_reg <= bitcnt_reg + 1'b1;
              state_reg  <= LO;
            end else begin
              cpy       <= 1'b1;
              state_reg <= COPY;
            end
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        COPY: begin
          if (div_end) begin
            cpy       <= 1'b0;
            sdata     <= 1'b0;
            div_reg   <= '0;
            state_reg <= IDLE;
`ifdef SHIFT_TX_DRIVER_DONE_EN
            done      <= 1'b1;
`endif
          end else begin
            div_reg <= div_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_tx_driver.sv
// Directed bench for shift_tx_driver (WIDTH=8, CLK_DIV=2) with a downstream SIPO model and word scoreboard.
// Done-pulse checks are compiled in when SHIFT_TX_DRIVER_DONE_EN is defined.
module tb_shift_tx_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready, sclk, sdata, cpy;
`ifdef SHIFT_TX_DRIVER_DONE_EN
  logic       done;
`endif

  shift_tx_driver #(.WIDTH(8), .CLK_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sclk      (sclk),
    .sdata     (sdata),
    .cpy       (cpy)
`ifdef SHIFT_TX_DRIVER_DONE_EN
    ,
    .done      (done)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream SIPO stage model
  logic [7:0] sr  = 8'h00;
  logic [7:0] par = 8'h00;
  always @(posedge sclk) sr  <= {sr[6:0], sdata};
  always @(posedge cpy)  par <= sr;

  // Scoreboard of words expected to appear on the parallel output
  logic [7:0] exp_q[$];

  // Event log, sampled on the falling clk edge
  int   rise_cyc[$];
  logic rise_bit[$];
  int   cpy_rise, cpy_fall, ready_rise, cpy_cnt, done_cyc, done_cnt;
  logic prev_sclk = 1'b0, prev_cpy = 1'b0, prev_ready = 1'b0;

  task automatic clear_logs();
    rise_cyc.delete();
    rise_bit.delete();
    cpy_rise = -1; cpy_fall = -1; ready_rise = -1;
    cpy_cnt = 0; done_cyc = -1; done_cnt = 0;
  endtask

  always @(negedge clk) begin
    chk("sclk_cpy_exclusive", 32'(sclk & cpy), 32'd0);
    if (sclk && !prev_sclk) begin
      rise_cyc.push_back(cyc);
      rise_bit.push_back(sdata);
    end
    if (cpy && !prev_cpy) begin
      cpy_rise = cyc;
      cpy_cnt++;
      if (exp_q.size() == 0) chk("unexpected_cpy", 32'd1, 32'd0);
      else chk("parallel_word", 32'(par), 32'(exp_q.pop_front()));
    end
    if (!cpy && prev_cpy) cpy_fall = cyc;
    if (din_ready && !prev_ready) ready_rise = cyc;
`ifdef SHIFT_TX_DRIVER_DONE_EN
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end
`endif
    prev_sclk  = sclk;
    prev_cpy   = cpy;
    prev_ready = din_ready;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_until(input int target);
    int n = 0;
    while (cyc < target && n < 500) begin
      step();
      n++;
    end
    if (cyc < target) chk("wait_timeout", 32'(cyc), 32'(target));
  endtask

  // Offer a word when ready; e0 is the accepting clk edge number.
  task automatic send(input logic [7:0] w, input logic hold, output int e0);
    int n = 0;
    while (!din_ready && n < 200) begin
      step();
      n++;
    end
    if (!din_ready) chk("ready_timeout", 32'd0, 32'd1);
    clear_logs();
    exp_q.push_back(w);
    din = w;
    din_valid = 1'b1;
    e0 = cyc + 1;
    step();
    if (!hold) din_valid = 1'b0;
    chk("busy_after_accept", 32'(din_ready), 32'd0);
  endtask

  task automatic check_frame(input logic [7:0] w, input int e0);
    wait_until(e0 + 35);
    chk($sformatf("rises_%02h", w), 32'(rise_cyc.size()), 32'd8);
    for (int i = 0; i < 8 && i < rise_cyc.size(); i++) begin
      chk($sformatf("rise%0d_time_%02h", i, w), 32'(rise_cyc[i] - e0), 32'((2 * i + 1) * 2));
      chk($sformatf("rise%0d_bit_%02h", i, w), 32'(rise_bit[i]), 32'(w[7-i]));
    end
    chk($sformatf("cpy_rise_%02h", w), 32'(cpy_rise - e0), 32'd32);
    chk($sformatf("cpy_fall_%02h", w), 32'(cpy_fall - e0), 32'd34);
    chk($sformatf("cpy_count_%02h", w), 32'(cpy_cnt), 32'd1);
    chk($sformatf("ready_rise_%02h", w), 32'(ready_rise - e0), 32'd34);
    chk($sformatf("model_par_%02h", w), 32'(par), 32'(w));
`ifdef SHIFT_TX_DRIVER_DONE_EN
    chk($sformatf("done_count_%02h", w), 32'(done_cnt), 32'd1);
    chk($sformatf("done_time_%02h", w), 32'(done_cyc - e0), 32'd34);
`endif
    $display("frame %02h accepted at clk %0d: %0d sclk rises, cpy %0d..%0d", w, e0,
             rise_cyc.size(), cpy_rise, cpy_fall);
    clear_logs();
  endtask

  initial begin
    int e0, e0b;
    clear_logs();

    // Reset state
    repeat (3) step();
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_cpy", 32'(cpy), 32'd0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(din_ready), 32'd1);

    // 1: single word, one-cycle valid
    send(8'hA5, 1'b0, e0);
    check_frame(8'hA5, e0);

    // 2: valid held across two words; second accepted 35 clk later
    clear_logs();
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    din = 8'h3C;
    din_valid = 1'b1;
    e0 = cyc + 1;
    step();
    din = 8'hC3;
    check_frame(8'h3C, e0);
    chk("held_valid_accepted", 32'(din_ready), 32'd0);
    din_valid = 1'b0;
    check_frame(8'hC3, e0 + 35);

    // 3: activity on din/din_valid while busy is ignored
    send(8'h5A, 1'b0, e0);
    while (cyc < e0 + 33) begin
      din = 8'($urandom);
      din_valid = 1'($urandom_range(0, 1));
      step();
      chk("ready_low_while_busy", 32'(din_ready), 32'd0);
    end
    din_valid = 1'b0;
    check_frame(8'h5A, e0);

    // 4: reset at E0+10 aborts the frame without a copy
    send(8'hB4, 1'b0, e0);
    wait_until(e0 + 9);
    @(posedge clk);
    #1;
    chk("pre_abort_sclk", 32'(sclk), 32'd1);
    chk("pre_abort_sdata", 32'(sdata), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_sdata", 32'(sdata), 32'd0);
    chk("abort_cpy", 32'(cpy), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (40) step();
    void'(exp_q.pop_back());
    chk("abort_no_cpy", 32'(cpy_cnt), 32'd0);
    chk("abort_par_kept", 32'(par), 32'h5A);
    chk("abort_ready", 32'(din_ready), 32'd1);
`ifdef SHIFT_TX_DRIVER_DONE_EN
    chk("abort_no_done", 32'(done_cnt), 32'd0);
`endif
    $display("frame b4 aborted by rst at clk %0d, parallel kept %02h", e0 + 10, par);
    send(8'h69, 1'b0, e0b);
    check_frame(8'h69, e0b);

    // 5: constant-data words
    send(8'h00, 1'b0, e0);
    check_frame(8'h00, e0);
    send(8'hFF, 1'b0, e0);
    check_frame(8'hFF, e0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
